sprite_fill_engine: RTL
=======================

# sprite_fill_engine

Pixel-sweep engine that answers the movement controller's draw/erase requests. On a held start request it latches the sprite position and colour, then walks a SIZE×SIZE square one pixel per clock into the VGA adapter's plot port. When the sweep is finished it raises a level done flag until the request is withdrawn. It sits between control_top/datapath_top and the VGA adapter, replacing ad-hoc fill logic with a defined 4-phase handshake.

## Interface
- SIZE, 4 — sprite edge length in pixels; power of two, 2..8.
- X_MAX, 159 — last visible column.
- Y_MAX, 119 — last visible row.
- BG_COLOUR, 3'b000 — colour written during erase.
- clk  in  1  system clock (CLOCK_50 at top level).
- resetn  in  1  synchronous active-low reset, sampled on posedge clk.
- start_draw  in  1  draw request (SD); level, held until draw_done seen.
- start_erase  in  1  erase request (SE); level, held until erase_done seen.
- x_in  in  8  sprite top-left column.
- y_in  in  7  sprite top-left row.
- colour_in  in  3  sprite colour.
- draw_done  out  1  DD; high from sweep end until start_draw low.
- erase_done  out  1  DE; high from sweep end until start_erase low.
- vga_x  out  8  pixel column to adapter.
- vga_y  out  7  pixel row to adapter.
- vga_colour  out  3  pixel colour to adapter.
- vga_plot  out  1  write-enable to adapter, one pixel per cycle.
- busy  out  1  high in SCAN.

## Operation
- States: IDLE, SCAN, DONE.
- IDLE: if start_erase=1, go to SCAN with mode=ERASE. Else if start_draw=1, go to SCAN with mode=DRAW.
- On leaving IDLE, latch x0=x_in, y0=y_in, and col = (mode==ERASE) ? BG_COLOUR : colour_in. Clear pixel counter cnt.
- Simultaneous start_draw and start_erase: erase wins; the draw request stays pending.
- SCAN: cnt width is 2·log2(SIZE) bits. dx = cnt low half, dy = cnt high half.
- SCAN outputs: vga_x = x0+dx, vga_y = y0+dy, computed 9/8 bits wide. vga_colour = col.
- vga_plot = 1 only if x0+dx ≤ X_MAX and y0+dy ≤ Y_MAX. Off-screen pixels are clipped and consume a cycle with no wrap-around.
- cnt increments each SCAN cycle. When cnt reaches SIZE²−1, the next state is DONE.
- DONE: the done output matching mode is 1. Return to IDLE when the matching request is 0. The other request is ignored while in DONE.
- Inputs x_in, y_in and colour_in may change during SCAN with no effect.
- Reset, including mid-SCAN: state=IDLE, cnt=0, mode=DRAW. All outputs are 0: draw_done, erase_done, vga_plot, busy, vga_x, vga_y, vga_colour. x0/y0/col are cleared to 0.

## Timing
- Request sampled high at edge k in IDLE → SCAN at k+1. vga_plot is high for cycles k+1 .. k+SIZE² (16 for SIZE=4), subject to clipping.
- Pixel order: row-major, dx fastest. First pixel (x0,y0), last pixel (x0+SIZE−1, y0+SIZE−1).
- done rises at cycle k+SIZE²+1. With the controller dropping the request one cycle after seeing done, done falls 2 cycles later and IDLE is re-entered.
- Minimum spacing between the end of one request and acceptance of the next: 1 cycle in IDLE.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Configuration
- SPRITE_MASK_EN defined: a SIZE²-bit mask parameter MASK (default all 1s) is compiled in.
  - In DRAW mode, vga_plot is additionally ANDed with MASK[cnt]. This gives a shaped ship sprite.
  - ERASE mode ignores the mask and clears the full square.
  - Cycle count is unchanged.
- Not defined: no mask logic. A solid SIZE×SIZE square is drawn.

## Test plan
- Reset, then start_draw=1 with x_in=8, y_in=4, colour_in=3'b010 → 16 plots, (8,4) through (11,7) row-major, colour 010. draw_done rises at cycle 17 and falls one cycle after start_draw drops.
- start_erase at x_in=156, y_in=116 → 16 plots of BG_COLOUR covering (156..159, 116..119). erase_done asserts; draw_done stays 0.
- x_in=158, y_in=118, draw → plots only at (158,118), (159,118), (158,119), (159,119). done still at cycle 17.
- start_draw and start_erase raised together → erase sweep and erase_done only. After start_erase drops, the draw sweep starts with start_draw still high.
- resetn pulled low at the 6th SCAN cycle → next cycle vga_plot=0, busy=0, both done=0. A fresh request restarts from (x0,y0).
- With SPRITE_MASK_EN and MASK=16'h9009, draw → exactly 4 plots: corners (x0,y0), (x0+3,y0), (x0,y0+3), (x0+3,y0+3). Erase of the same location → 16 plots.

Source files
------------

// File: rtl/sprite_fill_engine_if.sv
// Request/plot bundle between the movement controller and sprite_fill_engine.
// Engine side uses slave; controller side uses master.
interface sprite_fill_engine_if;
  logic       start_draw;
  logic       start_erase;
  logic [7:0] x_in;
  logic [6:0] y_in;
  logic [2:0] colour_in;
  logic       draw_done;
  logic       erase_done;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  logic       vga_plot;
  logic       busy;

  modport slave (
    input  start_draw, start_erase,
    input  x_in, y_in, colour_in,
    output draw_done, erase_done,
    output vga_x, vga_y, vga_colour,
    output vga_plot, busy
  );

  modport master (
    output start_draw, start_erase,
    output x_in, y_in, colour_in,
    input  draw_done, erase_done,
    input  vga_x, vga_y, vga_colour,
    input  vga_plot, busy
  );
endinterface

// File: rtl/sprite_fill_engine.sv
// SIZE x SIZE sprite sweep into the VGA plot port, 4-phase req/done.
// Optional SPRITE_MASK_EN compiles in a per-pixel draw mask MASK.
module sprite_fill_engine #(
  parameter int SIZE  = 4,
  parameter int X_MAX = 159,
  parameter int Y_MAX = 119,
`ifdef SPRITE_MASK_EN
  parameter logic [2:0] BG_COLOUR = 3'b000,
  parameter logic [SIZE*SIZE-1:0] MASK = '1
`else
  parameter logic [2:0] BG_COLOUR = 3'b000
`endif
) (
  input logic clk,
  input logic resetn,
  sprite_fill_engine_if.slave bus
);
  localparam int HW = $clog2(SIZE);
  localparam int CW = 2 * HW;

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
  typedef enum logic {DRAW, ERASE} mode_t;

  state_t        state, state_n;
  mode_t         mode, mode_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [7:0]    x0, x0_n;
  logic [6:0]    y0, y0_n;
  logic [2:0]    col, col_n;
  logic [8:0]    px;
  logic [7:0]    py;
  logic          plot_n;
  logic          req_mine;

  assign req_mine = (mode == ERASE) ? bus.start_erase
                                    : bus.start_draw;

  always_comb begin
    state_n = state;
    mode_n  = mode;
    cnt_n   = cnt;
    x0_n    = x0;
    y0_n    = y0;
    col_n   = col;
    unique case (state)
      IDLE: begin
        if (bus.start_erase) begin
          state_n = SCAN;
          mode_n  = ERASE;
          x0_n    = bus.x_in;
          y0_n    = bus.y_in;
          col_n   = BG_COLOUR;
          cnt_n   = '0;
        end else if (bus.start_draw) begin
          state_n = SCAN;
          mode_n  = DRAW;
          x0_n    = bus.x_in;
          y0_n    = bus.y_in;
          col_n   = bus.colour_in;
          cnt_n   = '0;
        end
      end
      SCAN: begin
        cnt_n = cnt + 1'b1;
        if (cnt == '1) state_n = DONE;
      end
      DONE: begin
        if (!req_mine) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase

    // Outputs are registered from the state being entered,
    // so pixel 0 appears in the first SCAN cycle.
    px = {1'b0, x0_n} + 9'(cnt_n[HW-1:0]);
    py = {1'b0, y0_n} + 8'(cnt_n[CW-1:HW]);
    plot_n = (state_n == SCAN) &&
             (px <= 9'(X_MAX)) &&
             (py <= 8'(Y_MAX));
`ifdef SPRITE_MASK_EN
    if (mode_n == DRAW && !MASK[cnt_n]) plot_n = 1'b0;
`endif
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state          <= IDLE;
      mode           <= DRAW;
      cnt            <= '0;
      x0             <= '0;
      y0             <= '0;
      col            <= '0;
      bus.draw_done  <= 1'b0;
      bus.erase_done <= 1'b0;
      bus.vga_x      <= '0;
      bus.vga_y      <= '0;
      bus.vga_colour <= '0;
      bus.vga_plot   <= 1'b0;
      bus.busy       <= 1'b0;
    end else begin
      state          <= state_n;
      mode           <= mode_n;
      cnt            <= cnt_n;
      x0             <= x0_n;
      y0             <= y0_n;
      col            <= col_n;
      bus.draw_done  <= (state_n == DONE) && (mode_n == DRAW);
      bus.erase_done <= (state_n == DONE) && (mode_n == ERASE);
      bus.busy       <= (state_n == SCAN);
      bus.vga_plot   <= plot_n;
      bus.vga_x      <= (state_n == SCAN) ? px[7:0] : '0;
      bus.vga_y      <= (state_n == SCAN) ? py[6:0] : '0;
      bus.vga_colour <= (state_n == SCAN) ? col_n : '0;
    end
  end
endmodule
